// File: rtl/fire_dispatcher_pkg.sv
// Shared types for the fire dispatcher: FSM states, order payload, side codes.
package gg_dispatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        REARM = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] security_id;
        logic [63:0] price;
        logic [31:0] size;
        logic [1:0]  side;
    } order_t;

    localparam logic [1:0] BUY  = 2'd1;
    localparam logic [1:0] SELL = 2'd2;

    // 16-bit add that sticks at all ones instead of wrapping.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/fire_dispatcher_if.sv
// Order output channel: valid/ready handshake plus the latched payload.
interface fire_dispatcher_if #(
    parameter int MAX_INSTRUMENTS = 8
);
    localparam int IW = $clog2(MAX_INSTRUMENTS);

    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_slot;
    logic [31:0]   out_security_id;
    logic [63:0]   out_price;
    logic [31:0]   out_size;
    logic [1:0]    out_side;

    modport master (
        output out_valid, out_slot, out_security_id, out_price, out_size, out_side,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_slot, out_security_id, out_price, out_size, out_side,
        output out_ready
    );
endinterface

// File: rtl/fire_dispatcher_rr_arbiter.sv
// Combinational round-robin pick: first request strictly after last, wrapping.
module rr_arbiter #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] s;

    // Walk slots last+1 .. last+N (mod N); the first hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        s     = '0;
        for (int k = 1; k <= N; k++) begin
            s = IW'((int'(last) + k) % N);
            if (!any && req[s]) begin
                any      = 1'b1;
                grant[s] = 1'b1;
                idx      = s;
            end
        end
    end

endmodule

// File: rtl/fire_dispatcher.sv
// Turns sticky per-slot fire flags into a serial stream of orders, one slot
// at a time in round-robin order, and optionally re-arms the slot afterwards.
module fire_dispatcher
    import gg_dispatch_pkg::*;
#(
    parameter int MAX_INSTRUMENTS = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [MAX_INSTRUMENTS-1:0]        fires,
    input  logic [MAX_INSTRUMENTS-1:0]        auto_rearm,
    input  logic [MAX_INSTRUMENTS-1:0][31:0]  order_security_id,
    input  logic [MAX_INSTRUMENTS-1:0][63:0]  order_price,
    input  logic [MAX_INSTRUMENTS-1:0][31:0]  order_size,
    input  logic [MAX_INSTRUMENTS-1:0][1:0]   order_side,
    output logic [MAX_INSTRUMENTS-1:0]        rearm_n,
    output logic [15:0]                       dropped_count,
    fire_dispatcher_if.master                 bus
);

    localparam int N  = MAX_INSTRUMENTS;
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(N + 1);

    state_t        state, state_nxt;
    logic [N-1:0]  fires_q;
    logic [N-1:0]  pending;
    logic [N-1:0]  fire_edge;
    logic [N-1:0]  clr;
    logic [N-1:0]  drop;
    logic [CW-1:0] drop_n;
    logic [IW-1:0] last_grant;
    logic [N-1:0]  grant_oh;
    logic [IW-1:0] grant_idx;
    logic          grant_any;
    logic          load;
    logic          accept;
    logic          out_valid_q;
    logic [IW-1:0] out_slot_q;
    order_t        payload_q;
    order_t        payload_sel;

    assign fire_edge = fires & ~fires_q;
    // A slot being granted this cycle is not a drop: its new edge re-pends it.
    assign drop      = fire_edge & pending & ~clr;
    assign accept    = (state == SEND) && bus.out_ready;

    rr_arbiter #(.N(N), .IW(IW)) u_arb (
        .req   (pending),
        .last  (last_grant),
        .grant (grant_oh),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    // Snapshot of the granted slot's order fields.
    always_comb begin
        payload_sel             = '0;
        payload_sel.security_id = order_security_id[grant_idx];
        payload_sel.price       = order_price[grant_idx];
        payload_sel.size        = order_size[grant_idx];
        payload_sel.side        = order_side[grant_idx];
    end

    // Number of fire edges lost this cycle (several slots may drop at once).
    always_comb begin
        drop_n = '0;
        for (int i = 0; i < N; i++) drop_n = drop_n + CW'(drop[i]);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // FSM next state, grant load and pending clear.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        clr       = '0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    load      = 1'b1;
                    clr       = grant_oh;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (bus.out_ready) state_nxt = auto_rearm[out_slot_q] ? REARM : IDLE;
            end
            REARM:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Edge history, pending set/clear (set wins) and drop counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fires_q       <= '0;
            pending       <= '0;
            dropped_count <= '0;
        end else begin
            fires_q       <= fires;
            pending       <= (pending & ~clr) | fire_edge;
            dropped_count <= sat_add16(dropped_count, 16'(drop_n));
        end
    end

    // Output registers: payload latched at grant, held until accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant  <= IW'(N - 1);
            out_valid_q <= 1'b0;
            out_slot_q  <= '0;
            payload_q   <= '0;
        end else if (load) begin
            last_grant  <= grant_idx;
            out_valid_q <= 1'b1;
            out_slot_q  <= grant_idx;
            payload_q   <= payload_sel;
        end else if (accept) begin
            out_valid_q <= 1'b0;
        end
    end

    // One-cycle active-low re-arm pulse, issued in the REARM state.
    always_ff @(posedge clk) begin
        if (!rst)
            rearm_n <= '1;
        else if (accept && auto_rearm[out_slot_q])
            rearm_n <= ~({{(N-1){1'b0}}, 1'b1} << out_slot_q);
        else
            rearm_n <= '1;
    end

    assign bus.out_valid       = out_valid_q;
    assign bus.out_slot        = out_slot_q;
    assign bus.out_security_id = payload_q.security_id;
    assign bus.out_price       = payload_q.price;
    assign bus.out_size        = payload_q.size;
    assign bus.out_side        = payload_q.side;

endmodule

// File: doc/fire_dispatcher.md
FIRE_DISPATCHER -- requirements
Module: fire_dispatcher

Interface
REQ-001 Parameter MAX_INSTRUMENTS, default 8: number of trigger slots; must match the upstream triggerer.
REQ-002 clk  in  1  single clock; all logic SHALL be on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 fires  in  MAX_INSTRUMENTS  level fire flags from the triggerer; sticky high until that slot is re-armed.
REQ-005 auto_rearm  in  MAX_INSTRUMENTS  per-slot enable for automatic re-arm after dispatch.
REQ-006 order_security_id  in  32 x MAX_INSTRUMENTS  per-slot order security id.
REQ-007 order_price  in  64 x MAX_INSTRUMENTS  per-slot order limit price.
REQ-008 order_size  in  32 x MAX_INSTRUMENTS  per-slot order quantity.
REQ-009 order_side  in  2 x MAX_INSTRUMENTS  per-slot side: 1 buy, 2 sell.
REQ-010 out_valid  out  1  order payload valid.
REQ-011 out_ready  in  1  downstream accepts the payload.
REQ-012 out_slot  out  $clog2(MAX_INSTRUMENTS)  index of the dispatched slot.
REQ-013 out_security_id, out_price, out_size, out_side  out  32/64/32/2  latched order payload.
REQ-014 rearm_n  out  MAX_INSTRUMENTS  active-low re-arm pulse per slot; drives the triggerer's rst_trigger.
REQ-015 dropped_count  out  16  count of fire edges lost because the slot was already pending; saturating.

Function
REQ-016 Rising-edge detect per slot: fire_edge[i] = fires[i] & ~fires_q[i], where fires_q is fires registered one cycle earlier.
REQ-017 fire_edge[i] SHALL set pending[i] at the end of the same cycle.
REQ-018 If pending[i] is already set when fire_edge[i] occurs, and is not being cleared that cycle, dropped_count SHALL increment, saturating at 0xFFFF.
REQ-019 If fire_edge[i] coincides with pending[i] being cleared by a grant, set SHALL win: pending[i] stays 1 and no drop is counted.
REQ-020 FSM states: IDLE, SEND, REARM.
REQ-021 IDLE with pending != 0:
  - grant one slot, round-robin, searching upward from last_grant+1 with wrap at MAX_INSTRUMENTS-1 -> 0;
  - latch that slot's order_* fields and index into the out_* registers;
  - clear pending[grant]; update last_grant;
  - go to SEND.
REQ-022 Latency: a fire edge in cycle t with FSM idle and no other pending slots SHALL give out_valid=1 in cycle t+2.
REQ-023 SEND: out_valid=1; out_* SHALL hold stable until the cycle in which out_ready=1.
REQ-024 In SEND with out_ready=1: if auto_rearm[out_slot] go to REARM, else go to IDLE; out_valid=0 the next cycle.
REQ-025 REARM: rearm_n[out_slot]=0 for exactly one cycle, all other rearm_n bits 1; then go to IDLE.
REQ-026 Order fields changing after the grant SHALL NOT affect the latched payload.
REQ-027 out_valid SHALL NOT depend combinationally on out_ready; all outputs are registered.
REQ-028 Maximum throughput: one order per 2 cycles (IDLE->SEND) with auto_rearm=0; one per 3 cycles with auto_rearm=1.

Reset
REQ-029 While rst=0 at a clock edge:
  - pending=0, fires_q=0, state=IDLE;
  - out_valid=0, out_* payload=0;
  - rearm_n=all ones, dropped_count=0;
  - last_grant=MAX_INSTRUMENTS-1, so the first grant searches from slot 0.
REQ-030 Reset asserted during SEND SHALL abandon the order: out_valid=0 the next cycle, and no rearm pulse is issued.
REQ-031 After reset, fires already high SHALL register as edges, because fires_q=0.

Structure
REQ-032 Package gg_dispatch_pkg SHALL hold the state enum, the packed order struct (security id 32, price 64, size 32, side 2) and side constants BUY=1, SELL=2.
REQ-033 Round-robin selection SHALL be a sub-module rr_arbiter (request vector and last grant in; one-hot grant and index out; combinational).

Verification
REQ-034 Reset, then fires[3] rises at cycle 10 with out_ready=1 and auto_rearm=0 -> out_valid=1 at cycle 12, out_slot=3 with slot 3's fields, out_valid=0 at cycle 13.
REQ-035 fires[1], fires[5] and fires[6] rise in the same cycle, out_ready=1 -> dispatch order 1, 5, 6; a later fires[0] edge dispatches before any wrap back to 1.
REQ-036 out_ready held 0 for 5 cycles in SEND while order_price changes -> payload stays constant; accepted on the first ready cycle.
REQ-037 auto_rearm[2]=1, slot 2 dispatched and accepted -> rearm_n[2]=0 for exactly one cycle; the triggerer model drops fires[2]; a new fires[2] rise re-dispatches.
REQ-038 Slot 4 pending, FSM stalled by out_ready=0, fires[4] toggles low then high -> dropped_count=1; forcing 70000 such drops -> dropped_count=0xFFFF.
REQ-039 rst=0 asserted in SEND -> out_valid=0 next cycle, all rearm_n stay 1, pending=0.
